// File: rtl/ps2_scan_tracker_pkg.sv
// Shared constants and types for the PS/2 scancode tracker.
package ps2_scan_tracker_pkg;

    // Prefix bytes from the keyboard
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS = 11;

    // Scancode interpreter states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        BRK  = 2'd2
    } scan_state_t;

    // Odd parity: data bits plus parity bit must contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scan_tracker_if.sv
// Keyboard pins plus the display-facing results of the scancode tracker.
interface ps2_scan_tracker_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       key_down;
    logic [7:0] press_cnt;
    logic       frame_err;

    // Tracker side: consumes the PS/2 lines, drives the decoder inputs
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output code,
        output key_down,
        output press_cnt,
        output frame_err
    );

    // Keyboard/board side: drives the PS/2 lines, observes the results
    modport master (
        output ps2_clk,
        output ps2_data,
        input  code,
        input  key_down,
        input  press_cnt,
        input  frame_err
    );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 deframer: synchronizes the raw keyboard lines, detects falling clock
// edges, assembles 11-bit frames, checks start/stop/parity and abandons
// frames that stall for TIMEOUT_CYCLES.
module ps2_rx_frame
    import ps2_scan_tracker_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_frame_err
);

    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAST_IX = FRAME_BITS - 1;

    logic [2:0]            r_clk_sync;
    logic [2:0]            r_data_sync;
    logic [3:0]            r_bit_cnt;
    logic [FRAME_BITS-2:0] r_shift;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_rx_valid;
    logic [7:0]            r_rx_byte;
    logic                  r_frame_err;

    logic                  w_fall;
    logic                  w_data;
    logic                  w_last_bit;
    logic                  w_frame_ok;

    // Synchronizers preset to the idle-high bus level so reset creates no edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[1:0], i_ps2_data};
        end
    end

    // Data is taken from the same sync stage as the newer clock sample
    assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_data     = r_data_sync[1];
    assign w_last_bit = (r_bit_cnt == 4'(LAST_IX));

    // r_shift holds start (bit 0), d0..d7 (bits 8:1), parity (bit 9); stop is live
    assign w_frame_ok = ~r_shift[0] & w_data & odd_parity_ok(r_shift[8:1], r_shift[9]);

    // Bit counter, frame assembly, validity check and stall timeout
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_to_cnt    <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_byte   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (w_last_bit) begin
                    r_bit_cnt <= '0;
                    if (w_frame_ok) begin
                        r_rx_valid <= 1'b1;
                        r_rx_byte  <= r_shift[8:1];
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else begin
                    r_shift   <= {w_data, r_shift[FRAME_BITS-2:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != '0) begin
                if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    r_bit_cnt   <= '0;
                    r_to_cnt    <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign o_rx_valid  = r_rx_valid;
    assign o_rx_byte   = r_rx_byte;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ps2_scan_tracker.sv
// PS/2 scancode tracker: interprets make/break/extended bytes from the
// deframer and presents the last pressed key, a held flag and a press count.
module ps2_scan_tracker
    import ps2_scan_tracker_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                clrn,
    ps2_scan_tracker_if.slave   bus
);

    logic        w_rx_valid;
    logic [7:0]  w_rx_byte;
    logic        w_frame_err;

    scan_state_t r_state;
    scan_state_t w_state_nxt;
    logic [7:0]  r_code;
    logic [7:0]  w_code_nxt;
    logic        r_key_down;
    logic        w_key_down_nxt;
    logic [7:0]  r_press_cnt;
    logic [7:0]  w_press_cnt_nxt;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk       (clk),
        .i_rst_n     (clrn),
        .i_ps2_clk   (bus.ps2_clk),
        .i_ps2_data  (bus.ps2_data),
        .o_rx_valid  (w_rx_valid),
        .o_rx_byte   (w_rx_byte),
        .o_frame_err (w_frame_err)
    );

    // State and output registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_key_down  <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_key_down  <= w_key_down_nxt;
            r_press_cnt <= w_press_cnt_nxt;
        end
    end

    // Scancode interpretation; E0 prefixes are transparent in every state
    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_key_down_nxt  = r_key_down;
        w_press_cnt_nxt = r_press_cnt;
        if (w_rx_valid && (w_rx_byte != SC_EXT)) begin
            unique case (r_state)
                IDLE: begin
                    if (w_rx_byte == SC_BREAK) begin
                        w_state_nxt = BRK;
                    end else begin
                        w_code_nxt      = w_rx_byte;
                        w_key_down_nxt  = 1'b1;
                        w_press_cnt_nxt = r_press_cnt + 8'd1;
                        w_state_nxt     = HELD;
                    end
                end
                HELD: begin
                    if (w_rx_byte == SC_BREAK) begin
                        w_state_nxt = BRK;
                    end else if (w_rx_byte != r_code) begin
                        w_code_nxt      = w_rx_byte;
                        w_press_cnt_nxt = r_press_cnt + 8'd1;
                    end
                end
                BRK: begin
                    if (w_rx_byte == SC_BREAK) begin
                        w_state_nxt = BRK;
                    end else if ((w_rx_byte == r_code) && r_key_down) begin
                        w_key_down_nxt = 1'b0;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_state_nxt = r_key_down ? HELD : IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign bus.code      = r_code;
    assign bus.key_down  = r_key_down;
    assign bus.press_cnt = r_press_cnt;
    assign bus.frame_err = w_frame_err;

endmodule
